// File: rtl/fdtd_pkg.sv
// rtl/fdtd_pkg.sv - shared state type and width helper for the variable delay line
package fdtd_pkg;

  // Line state: idle after reset, refilling after a restart, or delivering samples
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } fdtd_state_e;

  // Width needed to hold a delay value in 1..max_delay inclusive
  function automatic int fdtd_dly_w(input int max_delay);
    return $clog2(max_delay) + 1;
  endfunction

endpackage

// File: rtl/fdtd_delay_ram.sv
// rtl/fdtd_delay_ram.sv - circular sample store, synchronous write, asynchronous read
module fdtd_delay_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Data storage is deliberately not reset; validity lives in the parent's flop vector
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fdtd_var_delay.sv
// rtl/fdtd_var_delay.sv - variable-length sample delay line with load/flush restart
module fdtd_var_delay
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int MAX_DELAY = 16,
  localparam int DLY_W = fdtd_dly_w(MAX_DELAY)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [DLY_W-1:0]           dly_i,
  input  logic                       dly_ld_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [FDTD_DATA_WIDTH-1:0] data_i,
  output logic                       valid_o,
  output logic [FDTD_DATA_WIDTH-1:0] data_o,
  output logic                       fill_o
);

  localparam int AW = $clog2(MAX_DELAY);

  fdtd_state_e                state_q;
  fdtd_state_e                state_nxt;
  logic [AW-1:0]              wptr_q;
  logic [AW-1:0]              rd_idx;
  logic [DLY_W-1:0]           dly_q;
  logic [DLY_W-1:0]           dly_clamped;
  logic [DLY_W-1:0]           fill_cnt_q;
  logic [DLY_W-1:0]           fill_cnt_nxt;
  logic [MAX_DELAY-1:0]       vld_q;
  logic [FDTD_DATA_WIDTH-1:0] rd_data;
  logic                       restart;
  logic                       bypass;
  logic                       vld_rd;

  // A load and a flush restart the line identically; a load additionally changes D
  assign restart = dly_ld_i | flush_i;

  // With D=1 the output register takes the input directly, since the entry being
  // written this cycle is not yet visible on the asynchronous read port
  assign bypass = (dly_q == DLY_W'(1));

  // Output is registered, so the entry read now appears next cycle: look back D-1 slots
  assign rd_idx = AW'({1'b0, wptr_q} - dly_q + DLY_W'(1));
  assign vld_rd = bypass ? valid_i : vld_q[rd_idx];

  assign fill_o = (state_q == ST_FILL);

  fdtd_delay_ram #(
    .DEPTH (MAX_DELAY),
    .WIDTH (FDTD_DATA_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (1'b1),
    .waddr (wptr_q),
    .wdata (data_i),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Keep a requested delay inside the legal 1..MAX_DELAY range
  always_comb begin
    dly_clamped = dly_i;
    if (dly_i == '0) begin
      dly_clamped = DLY_W'(1);
    end else if (dly_i > DLY_W'(MAX_DELAY)) begin
      dly_clamped = DLY_W'(MAX_DELAY);
    end
  end

  // Next-state logic: restart always wins, otherwise count D fill cycles then run
  always_comb begin
    state_nxt    = state_q;
    fill_cnt_nxt = fill_cnt_q;
    if (restart) begin
      state_nxt    = ST_FILL;
      fill_cnt_nxt = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          state_nxt    = ST_FILL;
          fill_cnt_nxt = '0;
        end
        ST_FILL: begin
          if (fill_cnt_q == dly_q - DLY_W'(1)) begin
            state_nxt = ST_RUN;
          end else begin
            fill_cnt_nxt = fill_cnt_q + DLY_W'(1);
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt    = ST_EMPTY;
          fill_cnt_nxt = '0;
        end
      endcase
    end
  end

  // FSM state and fill counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_EMPTY;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt;
      fill_cnt_q <= fill_cnt_nxt;
    end
  end

  // Write pointer advances every cycle regardless of input validity
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(1);
    end
  end

  // Active delay: longest delay out of reset, clamped value on load
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dly_q <= DLY_W'(MAX_DELAY);
    end else if (dly_ld_i) begin
      dly_q <= dly_clamped;
    end
  end

  // Valid bits: restart wipes history, but the sample of the restart cycle is kept
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
    end else begin
      if (restart) begin
        vld_q <= '0;
      end
      vld_q[wptr_q] <= valid_i;
    end
  end

  // Registered outputs; valid only once the line is running
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= (state_nxt == ST_RUN) & vld_rd;
      data_o  <= bypass ? data_i : rd_data;
    end
  end

endmodule
